// File: rtl/mod_ctrl_if.sv
// mod_ctrl_if: operand/start handshake, datapath strobes and result valid/ready bundle for mod_ctrl.
interface mod_ctrl_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic [WIDTH-1:0] dp_a;
    logic [WIDTH-1:0] dp_b;
    logic             dp_load;
    logic             dp_subtract;
    logic             dp_done;
    logic [WIDTH-1:0] dp_result;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             result_ready;
    logic             div_by_zero;
    logic             timeout;
    modport slave (
        input  start, op_a, op_b, dp_done, dp_result, result_ready,
        output busy, dp_a, dp_b, dp_load, dp_subtract, result, result_valid, div_by_zero, timeout
    );
    modport master (
        output start, op_a, op_b, dp_done, dp_result, result_ready,
        input  busy, dp_a, dp_b, dp_load, dp_subtract, result, result_valid, div_by_zero, timeout
    );
endinterface

// File: rtl/mod_ctrl.sv
// mod_ctrl: sequences the mod_dp datapath (load, repeated subtract) and returns the remainder via valid/ready.
// Define MOD_CYCLE_COUNT_EN to add cycle_count_o, the SUB-cycle count of the last operation.
module mod_ctrl #(
    parameter int WIDTH    = 32,
    parameter int MAX_ITER = 1024,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef MOD_CYCLE_COUNT_EN
    output logic [CNT_W-1:0] cycle_count_o,
`endif
    mod_ctrl_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SUB, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             valid_q, valid_d, dbz_q, dbz_d, to_q, to_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cc_q, cc_d;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        valid_d = valid_q;
        dbz_d   = dbz_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        cc_d    = cc_q;
        case (state_q)
            IDLE: if (bus.start) begin
                a_d = bus.op_a;
                b_d = bus.op_b;
                if (bus.op_b == '0) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    dbz_d   = 1'b1;
                    res_d   = '0;
                    cc_d    = '0;
                end else begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = SUB;
            end
            SUB: begin
                // dp_done wins over the iteration limit when both land on the same cycle
                if (bus.dp_done || cnt_q == CNT_W'(MAX_ITER - 1)) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    to_d    = !bus.dp_done;
                    res_d   = bus.dp_done ? bus.dp_result : '0;
                    cc_d    = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: if (bus.result_ready) begin
                state_d = IDLE;
                valid_d = 1'b0;
                dbz_d   = 1'b0;
                to_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            cc_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            dbz_q   <= dbz_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            cc_q    <= cc_d;
        end
    end
    assign bus.busy         = state_q != IDLE;
    assign bus.dp_load      = state_q == LOAD;
    assign bus.dp_subtract  = state_q == SUB;
    assign bus.dp_a         = a_q;
    assign bus.dp_b         = b_q;
    assign bus.result       = res_q;
    assign bus.result_valid = valid_q;
    assign bus.div_by_zero  = dbz_q;
    assign bus.timeout      = to_q;
`ifdef MOD_CYCLE_COUNT_EN
    assign cycle_count_o = cc_q;
`else
    logic unused_cc;
    assign unused_cc = ^cc_q;
`endif
endmodule
